// File: rtl/nes_sram_arbiter_if.sv
// Bundle of the two requester ports plus the multiplexed-address SRAM pad signals.
// slave = arbiter side, master = requesters / pad bank side.
interface nes_sram_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [19:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p0_ack;
    logic [7:0]  p0_rdata;
    logic        p1_req;
    logic        p1_we;
    logic [19:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        p1_ack;
    logic [7:0]  p1_rdata;
    logic        busy;
    logic [1:0]  sram_ale;
    logic [3:0]  sram_adrh;
    logic        sram_cen;
    logic        sram_rdn;
    logic        sram_wdn;
    logic        sram_bus_oen;
    logic [7:0]  sram_do;
    logic [7:0]  sram_di;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, sram_di,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, busy,
               sram_ale, sram_adrh, sram_cen, sram_rdn, sram_wdn, sram_bus_oen, sram_do
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, sram_di,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, busy,
               sram_ale, sram_adrh, sram_cen, sram_rdn, sram_wdn, sram_bus_oen, sram_do
    );
endinterface

// File: rtl/nes_sram_arbiter.sv
// Two-port (PPU priority, CPU second) arbiter for the external 8-bit multiplexed-address SRAM.
// Optional SRAM_ALE_SKIP_EN: skip ALE phases whose address byte is already latched in the SRAM.
module nes_sram_arbiter #(
    parameter int ALE_CYCLES = 1,
    parameter int ACC_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    nes_sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALE0, ALE1, ACCESS, RECOVER} state_t;

    localparam logic [7:0] ALE_LAST = 8'(ALE_CYCLES - 1);
    localparam logic [7:0] ACC_LAST = 8'(ACC_CYCLES - 1);

    state_t          state, state_n;
    logic [7:0]      cnt;
    logic            phase_last;

    logic [1:0]      req, we_in;
    logic [1:0][19:0] addr_in;
    logic [1:0][7:0] wdata_in;

    logic            gnt, gnt_q, we_q, cur_we;
    logic [19:0]     addr_q, cur_addr;
    logic [7:0]      wdata_q, cur_wdata;
    logic            need_lo, need_mid;

    logic [1:0]      ale_q, ale_n;
    logic [3:0]      adrh_q, adrh_n;
    logic            cen_q, cen_n, rdn_q, rdn_n, wdn_q, wdn_n, oen_q, oen_n, busy_q, busy_n;
    logic [7:0]      do_q, do_n;
    logic [1:0]      ack_q;
    logic [1:0][7:0] rdata_q;

    assign req      = {bus.p1_req, bus.p0_req};
    assign we_in    = {bus.p1_we, bus.p0_we};
    assign addr_in  = {bus.p1_addr, bus.p0_addr};
    assign wdata_in = {bus.p1_wdata, bus.p0_wdata};
    assign gnt      = ~req[0];

    // In IDLE the granted port's inputs feed the output registers directly; afterwards the copy.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we_in[gnt];
            cur_addr  = addr_in[gnt];
            cur_wdata = wdata_in[gnt];
        end
    end

    assign phase_last = (state == ACCESS) ? (cnt == ACC_LAST) : (cnt == ALE_LAST);

`ifdef SRAM_ALE_SKIP_EN
    logic       lo_v, mid_v;
    logic [7:0] lo_q, mid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_v  <= 1'b0;
            mid_v <= 1'b0;
            lo_q  <= '0;
            mid_q <= '0;
        end else begin
            if (state == ALE0) begin
                lo_v <= 1'b1;
                lo_q <= addr_q[7:0];
            end
            if (state == ALE1) begin
                mid_v <= 1'b1;
                mid_q <= addr_q[15:8];
            end
        end
    end

    assign need_lo  = !(lo_v && (lo_q == cur_addr[7:0]));
    assign need_mid = !(mid_v && (mid_q == cur_addr[15:8]));
`else
    assign need_lo  = 1'b1;
    assign need_mid = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == state) ? cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req) state_n = need_lo ? ALE0 : (need_mid ? ALE1 : ACCESS);
            ALE0:    if (phase_last) state_n = need_mid ? ALE1 : ACCESS;
            ALE1:    if (phase_last) state_n = ACCESS;
            ACCESS:  if (phase_last) state_n = RECOVER;
            RECOVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output values are decoded from the next state so the pads change on the state edge.
    always_comb begin
        ale_n  = 2'b00;
        adrh_n = adrh_q;
        cen_n  = 1'b1;
        rdn_n  = 1'b1;
        wdn_n  = 1'b1;
        oen_n  = 1'b1;
        do_n   = do_q;
        busy_n = (state_n != IDLE);
        case (state_n)
            ALE0: begin
                ale_n  = 2'b01;
                oen_n  = 1'b0;
                do_n   = cur_addr[7:0];
                adrh_n = cur_addr[19:16];
            end
            ALE1: begin
                ale_n  = 2'b10;
                oen_n  = 1'b0;
                do_n   = cur_addr[15:8];
                adrh_n = cur_addr[19:16];
            end
            ACCESS: begin
                cen_n  = 1'b0;
                adrh_n = cur_addr[19:16];
                if (cur_we) begin
                    wdn_n = 1'b0;
                    oen_n = 1'b0;
                    do_n  = cur_wdata;
                end else begin
                    rdn_n = 1'b0;
                end
            end
            RECOVER: begin
                if (cur_we) begin
                    oen_n = 1'b0;
                    do_n  = cur_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && |req) begin
            gnt_q   <= gnt;
            we_q    <= cur_we;
            addr_q  <= cur_addr;
            wdata_q <= cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ale_q   <= 2'b00;
            adrh_q  <= '0;
            cen_q   <= 1'b1;
            rdn_q   <= 1'b1;
            wdn_q   <= 1'b1;
            oen_q   <= 1'b1;
            do_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            ale_q  <= ale_n;
            adrh_q <= adrh_n;
            cen_q  <= cen_n;
            rdn_q  <= rdn_n;
            wdn_q  <= wdn_n;
            oen_q  <= oen_n;
            do_q   <= do_n;
            busy_q <= busy_n;
            ack_q  <= '0;
            if (state == ACCESS && phase_last) begin
                ack_q[gnt_q] <= 1'b1;
                if (!we_q) rdata_q[gnt_q] <= bus.sram_di;
            end
        end
    end

    assign bus.sram_ale     = ale_q;
    assign bus.sram_adrh    = adrh_q;
    assign bus.sram_cen     = cen_q;
    assign bus.sram_rdn     = rdn_q;
    assign bus.sram_wdn     = wdn_q;
    assign bus.sram_bus_oen = oen_q;
    assign bus.sram_do      = do_q;
    assign bus.busy         = busy_q;
    assign bus.p0_ack       = ack_q[0];
    assign bus.p1_ack       = ack_q[1];
    assign bus.p0_rdata     = rdata_q[0];
    assign bus.p1_rdata     = rdata_q[1];
endmodule
